// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the stall controller: stall bus patterns,
// memory-port FSM encoding and the port arbitration rule.
package stall_ctrl_pkg;

  typedef logic [5:0] stall_bus_t;

  localparam stall_bus_t StallMem  = 6'b011111;
  localparam stall_bus_t StallLd   = 6'b001111;
  localparam stall_bus_t StallIf   = 6'b000111;
  localparam stall_bus_t StallNone = 6'b000000;

  localparam logic RstEnable = 1'b0;

  typedef enum logic [1:0] {
    PORT_IDLE     = 2'd0,
    PORT_IF_BUSY  = 2'd1,
    PORT_MEM_BUSY = 2'd2
  } port_state_e;

  // MEM wins the port over IF whenever both want it.
  function automatic port_state_e arbitrate(input logic mem_req, input logic if_req);
    if (mem_req) return PORT_MEM_BUSY;
    else if (if_req) return PORT_IF_BUSY;
    else return PORT_IDLE;
  endfunction

endpackage

// File: rtl/stall_ctrl_mem_port_arb.sv
// Shared memory-port arbiter between fetch and MEM: ownership FSM, registered
// grants and the wrong-path fetch discard flag.
module mem_port_arb
  import stall_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_done,
  input  logic mem_req,
  input  logic mem_done,
  input  logic flush,
  output logic if_grant,
  output logic mem_grant,
  output logic if_discard
);

  port_state_e state_reg, state_next;
  logic        discard_reg, discard_next;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_reg   <= PORT_IDLE;
      discard_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      discard_reg <= discard_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    // Completion re-arbitrates in the same cycle so the port never idles.
    case (state_reg)
      PORT_IDLE:     state_next = arbitrate(mem_req, if_req);
      PORT_IF_BUSY:  if (if_done) state_next = arbitrate(mem_req, if_req);
      PORT_MEM_BUSY: if (mem_done) state_next = arbitrate(mem_req, if_req);
      default:       state_next = PORT_IDLE;
    endcase
    if (state_reg == PORT_IF_BUSY) begin
      if (if_done) discard_next = 1'b0;
      else if (flush) discard_next = 1'b1;
    end
  end

  assign if_grant   = (state_reg == PORT_IF_BUSY);
  assign mem_grant  = (state_reg == PORT_MEM_BUSY);
  // A flush landing on the completion cycle discards directly without the flag.
  assign if_discard = if_grant & if_done & (discard_reg | flush);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller driving the 6-bit stall bus.
// Optional STALL_CTRL_PERF_EN adds per-cause stall cycle counters.
module stall_ctrl
  import stall_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req_i,
  input  logic       if_done_i,
  input  logic       mem_req_i,
  input  logic       mem_done_i,
  input  logic       id_stallreq_i,
  input  logic       ex_branch_i,
  output logic       if_grant_o,
  output logic       mem_grant_o,
  output logic       if_discard_o,
  output logic       flush_o,
  output logic [5:0] stall_o
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0] perf_mem_o,
  output logic [31:0] perf_ld_o,
  output logic [31:0] perf_if_o
`endif
);

  logic mem_wait, ld_wait, if_wait;
  stall_bus_t stall_bus;

  // Waits drop in the done cycle so the waiting register loads on that edge.
  assign mem_wait = mem_req_i & ~(mem_grant_o & mem_done_i);
  assign ld_wait  = id_stallreq_i;
  assign if_wait  = if_req_i & ~(if_grant_o & if_done_i);

  always_comb begin
    stall_bus = StallNone;
    if (mem_wait)     stall_bus = StallMem;
    else if (ld_wait) stall_bus = StallLd;
    else if (if_wait) stall_bus = StallIf;
  end

  assign stall_o = stall_bus;
  // A held EX/MEM means the branch will be re-presented later.
  assign flush_o = ex_branch_i & ~stall_bus[4];

  mem_port_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req_i),
    .if_done    (if_done_i),
    .mem_req    (mem_req_i),
    .mem_done   (mem_done_i),
    .flush      (flush_o),
    .if_grant   (if_grant_o),
    .mem_grant  (mem_grant_o),
    .if_discard (if_discard_o)
  );

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_mem_reg, perf_ld_reg, perf_if_reg;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      perf_mem_reg <= 32'd0;
      perf_ld_reg  <= 32'd0;
      perf_if_reg  <= 32'd0;
    end else if (mem_wait) begin
      perf_mem_reg <= perf_mem_reg + 32'd1;
    end else if (ld_wait) begin
      perf_ld_reg <= perf_ld_reg + 32'd1;
    end else if (if_wait) begin
      perf_if_reg <= perf_if_reg + 32'd1;
    end
  end

  assign perf_mem_o = perf_mem_reg;
  assign perf_ld_o  = perf_ld_reg;
  assign perf_if_o  = perf_if_reg;
`endif

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline hazard and stall controller: the producer side of the 6-bit stall bus consumed by the pipeline registers and the PC/fetch unit. It merges stall requests from IF (fetch waiting on memory), ID (load-use) and MEM (load/store waiting on memory), and squashes wrong-path instructions on a taken branch from EX. It also arbitrates the single shared memory port between IF and MEM, so stall decisions follow actual port ownership. Sits beside the five-stage pipeline; every pipeline register reads its own stall bit and the next one.

## Interface
Parameters:
- none; widths come from shared defines (`StallBus` = [5:0]).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on posedge clk)
- if_req_i  in  1  fetch unit needs an instruction word
- if_done_i  in  1  memory controller: granted fetch complete this cycle
- mem_req_i  in  1  MEM stage load/store needs the port
- mem_done_i  in  1  memory controller: granted load/store complete this cycle
- id_stallreq_i  in  1  ID load-use hazard
- ex_branch_i  in  1  EX resolved a taken branch/jump this cycle
- if_grant_o  out  1  memory port owned by IF
- mem_grant_o  out  1  memory port owned by MEM
- if_discard_o  out  1  completing fetch is wrong-path; drop its data
- flush_o  out  1  load bubbles into IF/ID and ID/EX this cycle
- stall_o  out  6  bit0 PC, bit1 IF unit, bit2 IF/ID, bit3 ID/EX, bit4 EX/MEM, bit5 MEM/WB

## Operation
- Stall bus rule for consumers: register k loads when bit k=0; loads a bubble when bit k=1 and bit k+1=0; holds otherwise. stall_o is always a contiguous run of ones from bit0.
- Combinational causes: mem_wait = mem_req_i & ~(MEM_BUSY & mem_done_i); ld_wait = id_stallreq_i; if_wait = if_req_i & ~(IF_BUSY & if_done_i).
- Priority: mem_wait → 6'b011111; else ld_wait → 6'b001111; else if_wait → 6'b000111; else 6'b000000.
- Flush: flush_o = ex_branch_i & ~stall_o[4]. While EX/MEM is held, the branch is ignored; EX re-presents it once released. Flush overrides hold on IF/ID and ID/EX.
- Port FSM states IDLE, IF_BUSY, MEM_BUSY:
  - IDLE: mem_req_i → MEM_BUSY; else if_req_i → IF_BUSY.
  - BUSY: on matching done, re-arbitrate in the same cycle (MEM first) → MEM_BUSY / IF_BUSY / IDLE; no idle gap.
  - No preemption: mem_req_i during IF_BUSY waits for if_done_i.
  - Done strobes for the non-owning requester are ignored.
- Grants are registered: if_grant_o = (state==IF_BUSY), mem_grant_o = (state==MEM_BUSY).
- Discard flag: set when flush_o occurs in IF_BUSY and if_done_i=0; if_discard_o = flag & if_done_i; cleared on that done. If flush_o coincides with if_done_i, if_discard_o=1 that cycle and the flag is not set.

## Timing
- Reset (rst==0 at posedge): state IDLE, discard flag 0; so if_grant_o=0, mem_grant_o=0, if_discard_o=0. stall_o and flush_o are combinational and follow inputs.
- Request-to-grant latency: 1 cycle from IDLE.
- Release: stall deasserts in the done cycle; the waiting register loads on that edge.
- Reset mid-transaction: FSM returns to IDLE and the in-flight access is abandoned; the memory controller is reset by the same rst.

## Configuration
- STALL_CTRL_PERF_EN defined: adds outputs perf_mem_o, perf_ld_o, perf_if_o (32 bits each). Each cycle, only the winning cause's counter increments. Counters wrap at 2^32 and reset to 0.
- Undefined: no counter logic and no counter ports.

## Structure
- Shared defines: `StallBus`, stall patterns (StallMem, StallLd, StallIf, StallNone), FSM state encodings, RstEnable=1'b0.
- Sub-module mem_port_arb: FSM, grants and discard flag. stall_ctrl top level holds the stall/flush logic and counters.

## Test plan
- Reset held 2 cycles with if_req_i=1 → grants 0; after release, if_grant_o=1 next cycle; stall_o=000111 until if_done_i, then 000000.
- id_stallreq_i=1 alone for 1 cycle → stall_o=001111 that cycle.
- mem_req_i and if_req_i rise together from IDLE → mem_grant_o first; on mem_done_i, if_grant_o next cycle with no idle cycle; stall_o=011111 until mem_done_i.
- mem_req_i during IF_BUSY → IF stays owner until if_done_i; stall_o=011111 meanwhile.
- ex_branch_i in IF_BUSY, done two cycles later → flush_o=1 once, if_discard_o=1 exactly on done; ex_branch_i with mem_wait → flush_o=0.
- STALL_CTRL_PERF_EN: 3 mem-stall cycles, 1 load-use cycle → perf_mem_o=3, perf_ld_o=1, perf_if_o=0; preload 32'hFFFFFFFF, one more stall → 0.
